// File: rtl/core_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// core_bus_arbiter_if
//
// Purpose: bundles every bus-level signal around the two-master arbiter into
// one interface. This covers both master request/response channels, the shared
// slave bus and the grant indicator.
//
// Signals:
//   m0_* / m1_* : per-master channel
//                 req, we, address, write_data  -> into the arbiter
//                 ack, read_data, error         -> back to the master
//   cs, we, address, write_data                 : slave bus, driven by arbiter
//   read_data, error                            : slave response, valid while cs=1
//   grant                                       : owner of current/last transaction
//
// Modports:
//   master : the arbiter's view. The arbiter masters the slave bus and
//            answers both requesting masters.
//   slave  : the environment's view. This is the requesting masters together
//            with the addressed slave.
// -----------------------------------------------------------------------------
interface core_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);

  // master 0 channel
  logic                  m0_req;
  logic                  m0_we;
  logic [ADDR_WIDTH-1:0] m0_address;
  logic [DATA_WIDTH-1:0] m0_write_data;
  logic                  m0_ack;
  logic [DATA_WIDTH-1:0] m0_read_data;
  logic                  m0_error;

  // master 1 channel
  logic                  m1_req;
  logic                  m1_we;
  logic [ADDR_WIDTH-1:0] m1_address;
  logic [DATA_WIDTH-1:0] m1_write_data;
  logic                  m1_ack;
  logic [DATA_WIDTH-1:0] m1_read_data;
  logic                  m1_error;

  // shared slave bus
  logic                  cs;
  logic                  we;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  error;

  // arbitration status
  logic                  grant;

  modport master (
    input  m0_req, m0_we, m0_address, m0_write_data,
    output m0_ack, m0_read_data, m0_error,
    input  m1_req, m1_we, m1_address, m1_write_data,
    output m1_ack, m1_read_data, m1_error,
    output cs, we, address, write_data,
    input  read_data, error,
    output grant
  );

  modport slave (
    output m0_req, m0_we, m0_address, m0_write_data,
    input  m0_ack, m0_read_data, m0_error,
    output m1_req, m1_we, m1_address, m1_write_data,
    input  m1_ack, m1_read_data, m1_error,
    input  cs, we, address, write_data,
    output read_data, error,
    input  grant
  );

endinterface

// File: rtl/core_bus_arbiter.sv
// -----------------------------------------------------------------------------
// core_bus_arbiter
//
// Purpose: two-master, one-slave bus arbiter. Each transaction is a fixed
// three-cycle sequence:
//   IDLE  : sample both requests, pick a winner (round-robin on ties), latch
//           the winner's command
//   ISSUE : drive cs for one cycle; capture the slave response into the
//           winner's read_data/error registers at the closing edge
//   ACK   : pulse the winner's ack for one cycle, then return to IDLE
// This gives a throughput of one transaction every three cycles. Requests that
// arrive while the arbiter is busy are only seen at the next IDLE.
//
// Ports:
//   clk   : single clock, rising edge
//   reset : asynchronous, active-high; forces IDLE, clears all outputs and
//           sets grant=1 so that master 0 wins the first tie
//   bus   : core_bus_arbiter_if.master. It holds both master channels, the
//           slave bus and grant.
//
// ADDR_WIDTH/DATA_WIDTH must match the parameters of the connected interface
// instance.
// -----------------------------------------------------------------------------
module core_bus_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  core_bus_arbiter_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  // Latched command of the transaction in flight. These registers also hold
  // their values between transactions, so that the slave address and data
  // stay stable.
  logic                  grant_reg;
  logic                  lat_we_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;

  // Master channels gathered into index-addressable form.
  logic [1:0]            req_vec;
  logic [1:0]            we_vec;
  logic [ADDR_WIDTH-1:0] addr_vec  [2];
  logic [DATA_WIDTH-1:0] wdata_vec [2];

  // Decoded FSM outputs.
  logic       start;     // IDLE with at least one request: latch this cycle
  logic       winner;    // master index chosen in IDLE
  logic       cs_int;
  logic [1:0] ack_vec;

  assign req_vec      = {bus.m1_req, bus.m0_req};
  assign we_vec       = {bus.m1_we, bus.m0_we};
  assign addr_vec[0]  = bus.m0_address;
  assign addr_vec[1]  = bus.m1_address;
  assign wdata_vec[0] = bus.m0_write_data;
  assign wdata_vec[1] = bus.m1_write_data;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    winner     = grant_reg;
    cs_int     = 1'b0;
    ack_vec    = 2'b00;
    case (state_reg)
      IDLE: begin
        if (|req_vec) begin
          start = 1'b1;
          // On a tie, the master that did not own the last transaction wins.
          // With a single requester, req_vec[1] is its index.
          winner     = (&req_vec) ? ~grant_reg : req_vec[1];
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        cs_int     = 1'b1;
        state_next = ACK;
      end
      ACK: begin
        ack_vec    = grant_reg ? 2'b10 : 2'b01;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Command latch: only the winner's inputs are captured; the loser is ignored
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_reg  <= 1'b1;
      lat_we_reg <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
    end else if (start) begin
      grant_reg  <= winner;
      lat_we_reg <= we_vec[winner];
      addr_reg   <= addr_vec[winner];
      wdata_reg  <= wdata_vec[winner];
    end
  end

  // ---------------------------------------------------------------------------
  // Per-master response registers. Each one updates only at the closing edge
  // of its own ISSUE cycle, so the other master's transactions leave it
  // untouched. Read data is captured for writes too.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_resp
      logic [DATA_WIDTH-1:0] rdata_reg;
      logic                  err_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rdata_reg <= '0;
          err_reg   <= 1'b0;
        end else if (cs_int && (grant_reg == 1'(gi))) begin
          rdata_reg <= bus.read_data;
          err_reg   <= bus.error;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Output drive
  // ---------------------------------------------------------------------------
  assign bus.cs         = cs_int;
  assign bus.we         = cs_int & lat_we_reg;  // we only asserted with cs
  assign bus.address    = addr_reg;
  assign bus.write_data = wdata_reg;
  assign bus.grant      = grant_reg;

  assign bus.m0_ack       = ack_vec[0];
  assign bus.m0_read_data = g_resp[0].rdata_reg;
  assign bus.m0_error     = g_resp[0].err_reg;

  assign bus.m1_ack       = ack_vec[1];
  assign bus.m1_read_data = g_resp[1].rdata_reg;
  assign bus.m1_error     = g_resp[1].err_reg;

endmodule

// File: tb/tb_core_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_core_bus_arbiter
//
// Drives core_bus_arbiter through directed scenarios and then random traffic.
// The reference model is a transaction schedule: each time the arbiter can
// sample, it picks an owner and predicts cs one interval later and ack two
// intervals later. Inputs are driven on the falling edge, and outputs are
// compared on the falling edge.
// -----------------------------------------------------------------------------
module tb_core_bus_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  core_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  core_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state. k counts intervals between rising edges since
  // reset release.
  int            k, issue_k, ack_k, next_idle;
  bit            owner, last_grant, lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic [DW-1:0] exp_rd  [2];
  bit            exp_err [2];

  bit            order_q [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (interval %0d): got %0h expected %0h", tag, k, got, exp);
    end
  endtask

  task automatic set_m(input int i, input bit req, input bit we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (i == 0) begin
      bus.m0_req = req; bus.m0_we = we; bus.m0_address = a; bus.m0_write_data = d;
    end else begin
      bus.m1_req = req; bus.m1_we = we; bus.m1_address = a; bus.m1_write_data = d;
    end
  endtask

  task automatic model_reset();
    issue_k    = -100;
    ack_k      = -100;
    next_idle  = 0;
    owner      = 1'b0;
    last_grant = 1'b1;
    lat_we     = 1'b0;
    lat_addr   = '0;
    lat_wdata  = '0;
    exp_rd[0]  = '0;
    exp_rd[1]  = '0;
    exp_err[0] = 1'b0;
    exp_err[1] = 1'b0;
  endtask

  task automatic check_all();
    bit cs_e;
    cs_e = (k == issue_k);
    chk("cs",           64'(bus.cs),           64'(cs_e));
    chk("we",           64'(bus.we),           64'(cs_e & lat_we));
    chk("address",      64'(bus.address),      64'(lat_addr));
    chk("write_data",   64'(bus.write_data),   64'(lat_wdata));
    chk("m0_ack",       64'(bus.m0_ack),       64'((k == ack_k) && !owner));
    chk("m1_ack",       64'(bus.m1_ack),       64'((k == ack_k) && owner));
    chk("ack_excl",     64'(bus.m0_ack & bus.m1_ack), 64'd0);
    chk("grant",        64'(bus.grant),        64'(last_grant));
    chk("m0_read_data", 64'(bus.m0_read_data), 64'(exp_rd[0]));
    chk("m1_read_data", 64'(bus.m1_read_data), 64'(exp_rd[1]));
    chk("m0_error",     64'(bus.m0_error),     64'(exp_err[0]));
    chk("m1_error",     64'(bus.m1_error),     64'(exp_err[1]));
  endtask

  // Apply the model for the edge ending interval k, then move to the next
  // falling edge and compare.
  task automatic step();
    bit r0, r1;
    if (k == issue_k) begin
      exp_rd[owner]  = bus.read_data;
      exp_err[owner] = bus.error;
    end
    if (k == next_idle) begin
      r0 = bus.m0_req;
      r1 = bus.m1_req;
      if (r0 || r1) begin
        owner      = (r0 && r1) ? !last_grant : !r0;
        last_grant = owner;
        lat_we     = owner ? bus.m1_we         : bus.m0_we;
        lat_addr   = owner ? bus.m1_address    : bus.m0_address;
        lat_wdata  = owner ? bus.m1_write_data : bus.m0_write_data;
        issue_k    = k + 1;
        ack_k      = k + 2;
        next_idle  = k + 3;
      end else begin
        next_idle  = k + 1;
      end
    end
    @(negedge clk);
    k++;
    check_all();
  endtask

  // Assert reset asynchronously, check the reset values and release it on a
  // falling edge so that the next rising edge is the first sample.
  task automatic do_reset();
    set_m(0, 1'b0, 1'b0, '0, '0);
    set_m(1, 1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    k     = 0;
    model_reset();
  endtask

  task automatic rand_drive();
    bit cur_req, acked;
    for (int i = 0; i < 2; i++) begin
      cur_req = (i == 0) ? bus.m0_req : bus.m1_req;
      acked   = (k == ack_k) && (owner == (i == 1));
      if (!cur_req || acked) begin
        set_m(i, ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
              AW'($urandom()), DW'($urandom()));
      end
    end
    bus.read_data = DW'($urandom());
    bus.error     = ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    k = 0;
    model_reset();
    bus.read_data = '0;
    bus.error     = 1'b0;
    #2;
    do_reset();

    // Single read by m0.
    set_m(0, 1'b1, 1'b0, 16'h1000, 32'h0);
    bus.read_data = 32'hDEADBEEF;
    bus.error     = 1'b0;
    step();
    chk("rd_cs", 64'(bus.cs), 64'd1);
    chk("rd_addr", 64'(bus.address), 64'h1000);
    chk("rd_we", 64'(bus.we), 64'd0);
    step();
    chk("rd_ack", 64'(bus.m0_ack), 64'd1);
    chk("rd_data", 64'(bus.m0_read_data), 64'hDEADBEEF);
    chk("rd_err", 64'(bus.m0_error), 64'd0);
    set_m(0, 1'b0, 1'b0, 16'h1000, 32'h0);
    step();

    // Single write by m1.
    set_m(1, 1'b1, 1'b1, 16'h0008, 32'h00000005);
    bus.read_data = 32'h12345678;
    step();
    chk("wr_cs", 64'(bus.cs), 64'd1);
    chk("wr_we", 64'(bus.we), 64'd1);
    chk("wr_data", 64'(bus.write_data), 64'h5);
    step();
    chk("wr_ack", 64'(bus.m1_ack), 64'd1);
    chk("wr_grant", 64'(bus.grant), 64'd1);
    set_m(1, 1'b0, 1'b0, 16'h0008, 32'h0);
    step();

    // Error on an m1 read, then an error-free m1 read clears it.
    set_m(1, 1'b1, 1'b0, 16'h2000, 32'h0);
    bus.error = 1'b1;
    step();
    step();
    chk("err_m1", 64'(bus.m1_error), 64'd1);
    chk("err_m0", 64'(bus.m0_error), 64'd0);
    set_m(1, 1'b0, 1'b0, 16'h2000, 32'h0);
    bus.error = 1'b0;
    step();
    set_m(1, 1'b1, 1'b0, 16'h2004, 32'h0);
    step();
    step();
    chk("err_clr", 64'(bus.m1_error), 64'd0);
    set_m(1, 1'b0, 1'b0, 16'h2004, 32'h0);
    step();

    // m1 requests during the ACK of an m0 transaction.
    set_m(0, 1'b1, 1'b0, 16'h0100, 32'h0);
    step();
    step();
    set_m(0, 1'b0, 1'b0, 16'h0100, 32'h0);
    set_m(1, 1'b1, 1'b0, 16'h0200, 32'h0);
    step();
    chk("late_idle_cs", 64'(bus.cs), 64'd0);
    step();
    chk("late_cs", 64'(bus.cs), 64'd1);
    chk("late_grant", 64'(bus.grant), 64'd1);
    chk("late_addr", 64'(bus.address), 64'h0200);
    step();
    set_m(1, 1'b0, 1'b0, 16'h0200, 32'h0);
    step();

    // Both masters request continuously from reset.
    do_reset();
    set_m(0, 1'b1, 1'b1, 16'h0A00, 32'hA0A0A0A0);
    set_m(1, 1'b1, 1'b0, 16'h0B00, 32'hB0B0B0B0);
    order_q.delete();
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.cs) order_q.push_back(bus.grant);
    end
    chk("rr_count", 64'(order_q.size()), 64'd4);
    for (int i = 0; i < order_q.size(); i++) begin
      chk($sformatf("rr_order%0d", i), 64'(order_q[i]), 64'(i % 2));
    end
    set_m(0, 1'b0, 1'b0, '0, '0);
    set_m(1, 1'b0, 1'b0, '0, '0);
    step();
    step();
    step();

    // Reset while an m0 transaction is in ISSUE.
    set_m(0, 1'b1, 1'b1, 16'h0077, 32'h77777777);
    bus.read_data = 32'h55AA55AA;
    step();
    chk("pre_rst_cs", 64'(bus.cs), 64'd1);
    #2;
    do_reset();
    set_m(0, 1'b1, 1'b1, 16'h0042, 32'hCAFE0001);
    bus.read_data = 32'h0BADF00D;
    step();
    chk("post_rst_cs", 64'(bus.cs), 64'd1);
    step();
    chk("post_rst_ack", 64'(bus.m0_ack), 64'd1);
    chk("post_rst_rd", 64'(bus.m0_read_data), 64'h0BADF00D);
    set_m(0, 1'b0, 1'b0, 16'h0042, 32'h0);
    step();

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      rand_drive();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/core_bus_arbiter.md
CORE_BUS_ARBITER -- requirements
Module: core_bus_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, SHALL set the width of all address ports.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the width of all data ports.
REQ-003 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  in  1  SHALL be the reset: asynchronous, active-high.
REQ-005 m0_req  in  1  SHALL be the master 0 transaction request, held until m0_ack.
REQ-006 m0_we  in  1  SHALL be the master 0 write enable; 1 = write, 0 = read.
REQ-007 m0_address  in  ADDR_WIDTH  SHALL be the master 0 address.
REQ-008 m0_write_data  in  DATA_WIDTH  SHALL be the master 0 write data.
REQ-009 m0_ack  out  1  SHALL be the master 0 one-cycle completion pulse.
REQ-010 m0_read_data  out  DATA_WIDTH  SHALL be the master 0 registered read data.
REQ-011 m0_error  out  1  SHALL be the master 0 registered error flag.
REQ-012 m1_req, m1_we, m1_address, m1_write_data, m1_ack, m1_read_data, m1_error SHALL be identical to the m0_* ports, for master 1.
REQ-013 cs  out  1  SHALL be the slave bus chip select.
REQ-014 we  out  1  SHALL be the slave bus write enable.
REQ-015 address  out  ADDR_WIDTH  SHALL be the slave bus address.
REQ-016 write_data  out  DATA_WIDTH  SHALL be the slave bus write data.
REQ-017 read_data  in  DATA_WIDTH  SHALL be the slave read data, combinationally valid while cs=1.
REQ-018 error  in  1  SHALL be the slave error, combinationally valid while cs=1.
REQ-019 grant  out  1  SHALL identify the master owning the current or most recent transaction (0/1).

Function
REQ-020 The FSM SHALL have three states: IDLE, ISSUE, ACK.
REQ-021 IDLE: SHALL sample m0_req/m1_req; if any is high, latch the winner's we/address/write_data into registers, update grant, go to ISSUE; otherwise stay in IDLE.
REQ-022 Arbitration SHALL be round-robin: a single requester wins; with both requesting, the master not granted last wins.
REQ-023 ISSUE: cs=1 for exactly one cycle, with we/address/write_data driven from the latched registers.
REQ-024 ISSUE: at the closing edge, read_data and error SHALL be captured into the granted master's read_data/error registers; FSM goes to ACK.
REQ-025 On writes, the granted master's read_data register SHALL also capture the slave read_data (no special-casing).
REQ-026 ACK: the granted master's ack=1 for exactly one cycle; FSM returns to IDLE.
REQ-027 Latency: req high in IDLE at cycle N -> cs at N+1 -> ack at N+2 -> IDLE at N+3; throughput SHALL be one transaction per 3 cycles.
REQ-028 A master SHALL drop req at the edge ending its ack cycle; req still high in IDLE at N+3 SHALL be treated as a new transaction.
REQ-029 Requests arriving in ISSUE or ACK SHALL NOT be sampled; they wait for IDLE.
REQ-030 The losing master's inputs SHALL be ignored, and its ack/read_data/error SHALL remain unchanged during the other master's transaction.
REQ-031 m*_read_data/m*_error SHALL hold their values until that master's next completed transaction.
REQ-032 Outside ISSUE: cs=0, we=0; address and write_data SHALL hold their latched values.
REQ-033 The master 0 and master 1 acks SHALL never be high in the same cycle.

Reset
REQ-034 Asserting reset SHALL immediately force, regardless of state: IDLE, cs=0, we=0, address=0, write_data=0, both acks 0, both read_data 0, both error 0, grant=1 (master 0 wins the first tie).
REQ-035 A transaction interrupted by reset SHALL be abandoned without ack; masters re-request after reset deasserts.
REQ-036 The first IDLE sample SHALL occur on the first rising edge after reset deasserts.

Verification
REQ-037 Single read: m0 reads 16'h1000, slave returns 32'hDEADBEEF -> cs one cycle at N+1 with address=16'h1000, we=0; m0_ack at N+2 with m0_read_data=32'hDEADBEEF, m0_error=0.
REQ-038 Single write: m1 writes 32'h00000005 to 16'h0008 -> cs=1, we=1, write_data=32'h5 for one cycle; m1_ack at N+2; grant=1.
REQ-039 Contention: both masters request continuously from reset -> issue order m0, m1, m0, m1; acks 3 cycles apart and never coincident.
REQ-040 Error path: slave error=1 on an m1 read of 16'h2000 -> m1_error=1 with ack; m0_error unchanged; next m1 error-free transaction clears m1_error.
REQ-041 Reset mid-transaction: reset asserted during ISSUE -> cs drops asynchronously, no ack, all outputs at reset values; after release, a fresh m0 request completes normally.
REQ-042 Late request: m1_req rises during the ACK of an m0 transaction -> m1 issued at IDLE+1 with no skipped or duplicated transaction.
